// File: rtl/frame_wr_pkg.sv
// Shared constants for the camera-side DDR frame writer: FSM encoding and
// beat-to-byte conversion used by the burst address generator.
package frame_wr_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int DEFAULT_BYTES_PER_BEAT = 16;

  function automatic int bytes_per_beat(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/frame_ddr_writer.sv
// Streams one pixel frame into a DDR ping/pong buffer as fixed-length write
// bursts, one outstanding burst at a time, and reports a pass/fail token.
module frame_ddr_writer
  import frame_wr_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 128,
  parameter int                BURST_LEN   = 16,
  parameter int                FRAME_BEATS = 4096,
  parameter logic [ADDR_W-1:0] BUF0_BASE   = '0,
  parameter logic [ADDR_W-1:0] BUF1_BASE   = ADDR_W'(32'h0010_0000)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              ddr_write_start,
  input  logic              ddr_write_start_valid,
  output logic              ddr_write_start_ready,
  input  logic              odd_even_flag,
  input  logic [DATA_W-1:0] pix_tdata,
  input  logic              pix_tvalid,
  input  logic              pix_tlast,
  output logic              pix_tready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [7:0]        wr_cmd_len,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_data_valid,
  output logic              wr_data_last,
  input  logic              wr_data_ready,
  input  logic              wr_resp_valid,
  input  logic              wr_resp_ok,
  output logic              wr_resp_ready,
  output logic              ddr_write_finish,
  output logic              ddr_write_finish_valid,
  input  logic              ddr_write_finish_ready,
  output logic              busy
);

  localparam int NUM_BURSTS = FRAME_BEATS / BURST_LEN;
  localparam int BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int BEAT_W     = $clog2(BURST_LEN);

  localparam logic [ADDR_W-1:0]  BURST_BYTES = ADDR_W'(BURST_LEN * bytes_per_beat(DATA_W));
  localparam logic [BURST_W-1:0] LAST_BURST  = BURST_W'(NUM_BURSTS - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [7:0]         CMD_LEN     = 8'(BURST_LEN - 1);

  logic [2:0]         state;
  logic [ADDR_W-1:0]  base;
  logic [BURST_W-1:0] burst_idx;
  logic [BEAT_W-1:0]  beat_idx;
  logic               err;
  logic               armed;

  logic               start_hs;
  logic               beat_hs;
  logic               final_beat;
  logic [ADDR_W-1:0]  burst_addr;

  assign start_hs   = (state == ST_IDLE) && armed && ddr_write_start_valid;
  assign beat_hs    = (state == ST_DATA) && pix_tvalid && wr_data_ready;
  assign final_beat = (burst_idx == LAST_BURST) && (beat_idx == LAST_BEAT);
  assign burst_addr = base + ADDR_W'(burst_idx) * BURST_BYTES;
  assign busy       = (state != ST_IDLE);

  // armed keeps start_ready low for the cycle reset is released, so every output reads 0 in reset
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      base      <= '0;
      burst_idx <= '0;
      beat_idx  <= '0;
      err       <= 1'b0;
      armed     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_hs && ddr_write_start) begin
            base      <= odd_even_flag ? BUF1_BASE : BUF0_BASE;
            burst_idx <= '0;
            beat_idx  <= '0;
            err       <= 1'b0;
            state     <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (wr_cmd_ready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (beat_hs) begin
            beat_idx <= beat_idx + BEAT_W'(1);
            // tlast only flags framing errors; beat counting alone ends the frame
            if (pix_tlast != final_beat) err <= 1'b1;
            if (beat_idx == LAST_BEAT) state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (wr_resp_valid) begin
            if (!wr_resp_ok) err <= 1'b1;
            if (burst_idx == LAST_BURST) begin
              state <= ST_DONE;
            end else begin
              burst_idx <= burst_idx + BURST_W'(1);
              state     <= ST_CMD;
            end
          end
        end
        ST_DONE: begin
          if (ddr_write_finish_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output is defaulted first so no branch of the case can infer a latch.
    ddr_write_start_ready  = 1'b0;
    pix_tready             = 1'b0;
    wr_cmd_addr            = '0;
    wr_cmd_len             = '0;
    wr_cmd_valid           = 1'b0;
    wr_data                = '0;
    wr_data_valid          = 1'b0;
    wr_data_last           = 1'b0;
    wr_resp_ready          = 1'b0;
    ddr_write_finish       = 1'b0;
    ddr_write_finish_valid = 1'b0;
    case (state)
      ST_IDLE: ddr_write_start_ready = armed;
      ST_CMD: begin
        wr_cmd_valid = 1'b1;
        wr_cmd_addr  = burst_addr;
        wr_cmd_len   = CMD_LEN;
      end
      ST_DATA: begin
        wr_data       = pix_tdata;
        wr_data_valid = pix_tvalid;
        wr_data_last  = (beat_idx == LAST_BEAT);
        pix_tready    = wr_data_ready;
      end
      ST_RESP: wr_resp_ready = 1'b1;
      ST_DONE: begin
        ddr_write_finish_valid = 1'b1;
        ddr_write_finish       = ~err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_frame_ddr_writer.sv
// Randomized bench for frame_ddr_writer: a frame-level model predicts burst
// addresses, the beat stream, burst framing and the finish token.
module tb_frame_ddr_writer;

  localparam int          ADDR_W      = 32;
  localparam int          DATA_W      = 128;
  localparam int          BURST_LEN   = 16;
  localparam int          FRAME_BEATS = 32;
  localparam int          NUM_BURSTS  = FRAME_BEATS / BURST_LEN;
  localparam int          BEAT_BYTES  = DATA_W / 8;
  localparam logic [31:0] BUF0        = 32'h0000_0000;
  localparam logic [31:0] BUF1        = 32'h0010_0000;

  logic              clk = 1'b0;
  logic              areset;
  logic              ddr_write_start, ddr_write_start_valid, ddr_write_start_ready;
  logic              odd_even_flag;
  logic [DATA_W-1:0] pix_tdata;
  logic              pix_tvalid, pix_tlast, pix_tready;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [7:0]        wr_cmd_len;
  logic              wr_cmd_valid, wr_cmd_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_data_valid, wr_data_last, wr_data_ready;
  logic              wr_resp_valid, wr_resp_ok, wr_resp_ready;
  logic              ddr_write_finish, ddr_write_finish_valid, ddr_write_finish_ready;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  frame_ddr_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .FRAME_BEATS(FRAME_BEATS),
    .BUF0_BASE(BUF0), .BUF1_BASE(BUF1)
  ) dut (
    .clk(clk), .areset(areset),
    .ddr_write_start(ddr_write_start), .ddr_write_start_valid(ddr_write_start_valid),
    .ddr_write_start_ready(ddr_write_start_ready), .odd_even_flag(odd_even_flag),
    .pix_tdata(pix_tdata), .pix_tvalid(pix_tvalid), .pix_tlast(pix_tlast), .pix_tready(pix_tready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_cmd_valid(wr_cmd_valid),
    .wr_cmd_ready(wr_cmd_ready), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .wr_data_last(wr_data_last), .wr_data_ready(wr_data_ready),
    .wr_resp_valid(wr_resp_valid), .wr_resp_ok(wr_resp_ok), .wr_resp_ready(wr_resp_ready),
    .ddr_write_finish(ddr_write_finish), .ddr_write_finish_valid(ddr_write_finish_valid),
    .ddr_write_finish_ready(ddr_write_finish_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [135:0] all_outputs();
    return {ddr_write_start_ready, pix_tready, wr_cmd_valid, wr_data_valid, wr_data_last,
            wr_resp_ready, ddr_write_finish, ddr_write_finish_valid, busy,
            wr_cmd_len, wr_cmd_addr} | {8'd0, wr_data};
  endfunction

  // One frame; abort_at >= 0 stops observing once that many beats have been written.
  task automatic run_frame(input bit flag, input bit stall, input int tlast_pos,
                           input bit [NUM_BURSTS-1:0] ok_plan, input int abort_at);
    logic [DATA_W-1:0] pix [FRAME_BEATS];
    logic [31:0]       base;
    bit                exp_finish, started, finished, aborted, in_frame, fin_wait;
    int                dbeat, ncmd, nresp, start_cyc, last_resp_cyc;

    base       = flag ? BUF1 : BUF0;
    exp_finish = (ok_plan == '1) && (tlast_pos == FRAME_BEATS - 1);
    foreach (pix[i]) pix[i] = {$urandom, $urandom, $urandom, $urandom};
    {started, finished, aborted, in_frame, fin_wait} = '0;
    dbeat = 0; ncmd = 0; nresp = 0; start_cyc = -10; last_resp_cyc = -10;

    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ddr_write_start        = 1'b1;
      ddr_write_start_valid  = !started;
      odd_even_flag          = flag;
      pix_tvalid             = (dbeat < FRAME_BEATS) && (!stall || $urandom_range(1, 0) == 1);
      pix_tdata              = (dbeat < FRAME_BEATS) ? pix[dbeat] : '0;
      pix_tlast              = (dbeat == tlast_pos);
      wr_cmd_ready           = !stall || $urandom_range(1, 0) == 1;
      wr_data_ready          = !stall || $urandom_range(1, 0) == 1;
      ddr_write_finish_ready = !stall || $urandom_range(1, 0) == 1;
      wr_resp_valid          = started;
      wr_resp_ok             = (nresp < NUM_BURSTS) ? ok_plan[nresp] : 1'b1;

      @(negedge clk);
      check("busy", busy, in_frame);
      if (cyc == start_cyc + 1) check("start_to_cmd_latency", wr_cmd_valid, 1'b1);
      if (cyc == last_resp_cyc + 1) check("resp_to_finish_latency", ddr_write_finish_valid, 1'b1);
      if (fin_wait) check("finish_held", {ddr_write_finish_valid, ddr_write_finish}, {1'b1, exp_finish});
      fin_wait = 1'b0;

      if (!started && ddr_write_start_valid && ddr_write_start_ready) begin
        started   = 1'b1;
        start_cyc = cyc;
        in_frame  = 1'b1;
      end
      if (wr_cmd_valid) begin
        check("cmd_addr", wr_cmd_addr, base + ncmd * BURST_LEN * BEAT_BYTES);
        if (wr_cmd_ready) begin
          check("cmd_len", wr_cmd_len, BURST_LEN - 1);
          ncmd++;
        end
      end
      if (wr_data_valid && wr_data_ready) begin
        check("beat_data", wr_data, pix[dbeat]);
        check("beat_last", wr_data_last, (dbeat % BURST_LEN) == BURST_LEN - 1);
        dbeat++;
      end
      if (wr_resp_valid && wr_resp_ready) begin
        nresp++;
        if (nresp == NUM_BURSTS) last_resp_cyc = cyc;
      end
      if (ddr_write_finish_valid) begin
        if (ddr_write_finish_ready) begin
          check("finish_token", ddr_write_finish, exp_finish);
          check("beats_written", dbeat, FRAME_BEATS);
          check("bursts_issued", ncmd, NUM_BURSTS);
          finished = 1'b1;
        end else begin
          fin_wait = 1'b1;
        end
      end
      if (abort_at >= 0 && dbeat == abort_at) aborted = 1'b1;
      if (finished || aborted) break;
      @(posedge clk); #1;
    end

    if (!aborted) begin
      check("frame_completed", finished, 1'b1);
      @(posedge clk); #1;
      ddr_write_start_valid = 1'b0;
      @(negedge clk);
      check("idle_after_finish", {busy, ddr_write_start_ready}, 2'b01);
    end
  endtask

  initial begin
    areset = 1'b1;
    {ddr_write_start, ddr_write_start_valid, odd_even_flag, pix_tvalid, pix_tlast} = '0;
    pix_tdata = '0;
    {wr_cmd_ready, wr_data_ready, wr_resp_valid, wr_resp_ok, ddr_write_finish_ready} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outputs(), '0);
    @(posedge clk); #1;
    areset = 1'b0;

    // start=0 tokens are consumed without leaving IDLE
    ddr_write_start       = 1'b0;
    ddr_write_start_valid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("start0_ignored", {busy, wr_cmd_valid, ddr_write_start_ready}, 3'b001);
    @(posedge clk); #1;
    ddr_write_start_valid = 1'b0;

    run_frame(1'b0, 1'b0, FRAME_BEATS - 1, 2'b11, -1);
    run_frame(1'b1, 1'b0, FRAME_BEATS - 1, 2'b11, -1);
    run_frame(1'b0, 1'b0, FRAME_BEATS - 1, 2'b10, -1);
    run_frame(1'b1, 1'b0, 20, 2'b11, -1);
    run_frame(1'b0, 1'b0, FRAME_BEATS - 1, 2'b11, -1);

    for (int f = 0; f < 6; f++) begin
      run_frame(1'($urandom_range(1, 0)), 1'b1,
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(FRAME_BEATS - 1, 0)) : FRAME_BEATS - 1,
                2'($urandom_range(3, 0) | (f[0] ? 3 : 0)), -1);
    end

    // Abort part-way through the second burst, then restart from the buffer base
    run_frame(1'b1, 1'b0, FRAME_BEATS - 1, 2'b11, 20);
    @(posedge clk); #1;
    areset = 1'b1;
    @(negedge clk);
    check("abort_outputs_zero", all_outputs(), '0);
    @(posedge clk); #1;
    areset = 1'b0;
    ddr_write_start_valid = 1'b0;
    pix_tvalid            = 1'b0;
    @(negedge clk);
    check("abort_idle", {busy, wr_cmd_valid, wr_data_valid, ddr_write_finish_valid}, 4'b0000);
    run_frame(1'b0, 1'b0, FRAME_BEATS - 1, 2'b11, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
